// File: rtl/gpio_chk_pkg.sv
// Shared types and width helpers for the GPIO sequence checker.
package gpio_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } chk_state_t;

  localparam int SYNC_STAGES = 2;

  // Index width that stays at least one bit wide when there is a single entry.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchronizer bringing the asynchronous IO sample into wb_clk_i.
module gpio_sync
  import gpio_chk_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_sequence_checker.sv
// Walks a programmed sequence of masked IO patterns, each of which must hold for
// STABLE_CYCLES synchronized samples before its per-step timeout expires.
module gpio_sequence_checker
  import gpio_chk_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 4,
  parameter int TIMEOUT_W     = 16,
  parameter int STABLE_CYCLES = 2,
  localparam int AW = idx_w(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [WIDTH-1:0]     io_in,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [WIDTH-1:0]     cfg_pattern,
  input  logic [WIDTH-1:0]     cfg_mask,
  input  logic [LW-1:0]        cfg_len,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [AW-1:0]        step,
  output chk_state_t           state_dbg
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);

  // start/abort are single-cycle pulses with no handshake: abort wins over start,
  // start is only taken outside RUN, and cfg_we is only taken outside RUN.
  chk_state_t           state_q, state_d;
  logic [AW-1:0]        step_q, step_d;
  logic [SW-1:0]        stable_q, stable_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d, tmo_q, tmo_d;
  logic [LW-1:0]        len_q, len_d, len_clamped;
  logic [WIDTH-1:0]     io_sync;
  logic [WIDTH-1:0]     pattern_q [DEPTH];
  logic [WIDTH-1:0]     mask_q    [DEPTH];
  logic                 match, advance, last_step, tmo_hit;

  gpio_sync #(.WIDTH(WIDTH)) u_sync (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .d        (io_in),
    .q        (io_sync)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pattern_q[i] <= '0;
        mask_q[i]    <= '0;
      end
    end else if (cfg_we && (state_q != ST_RUN) && (32'(cfg_addr) < DEPTH)) begin
      pattern_q[cfg_addr] <= cfg_pattern;
      mask_q[cfg_addr]    <= cfg_mask;
    end
  end

  always_comb begin
    len_clamped = cfg_len;
    if (32'(cfg_len) > DEPTH) len_clamped = LW'(DEPTH);
  end

  assign match     = ((io_sync ^ pattern_q[step_q]) & mask_q[step_q]) == '0;
  assign advance   = match && (stable_q == SW'(STABLE_CYCLES - 1));
  assign last_step = (LW'(step_q) + LW'(1)) == len_q;
  assign tmo_hit   = (tmo_q != '0) && (timer_q == (tmo_q - TIMEOUT_W'(1)));

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    stable_d = stable_q;
    timer_d  = timer_q;
    len_d    = len_q;
    tmo_d    = tmo_q;
    if (abort) begin
      state_d  = ST_IDLE;
      step_d   = '0;
      stable_d = '0;
      timer_d  = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          timer_d = timer_q + TIMEOUT_W'(1);
          if (advance) begin
            stable_d = '0;
            if (last_step) begin
              state_d = ST_PASS;
            end else begin
              step_d  = step_q + AW'(1);
              timer_d = '0;
            end
          end else if (tmo_hit) begin
            state_d = ST_FAIL;
          end else begin
            stable_d = match ? (stable_q + SW'(1)) : '0;
          end
        end
        default: begin
          if (start) begin
            len_d    = len_clamped;
            tmo_d    = cfg_timeout;
            step_d   = '0;
            stable_d = '0;
            timer_d  = '0;
            state_d  = (len_clamped == '0) ? ST_PASS : ST_RUN;
          end
        end
      endcase
    end
  end

  // Flag outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      step_q   <= '0;
      stable_q <= '0;
      timer_q  <= '0;
      len_q    <= '0;
      tmo_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      stable_q <= stable_d;
      timer_q  <= timer_d;
      len_q    <= len_d;
      tmo_q    <= tmo_d;
      busy     <= (state_d == ST_RUN);
      done     <= (state_d == ST_PASS) || (state_d == ST_FAIL);
      pass     <= (state_d == ST_PASS);
    end
  end

  assign step      = step_q;
  assign state_dbg = state_q;

endmodule

// File: doc/gpio_sequence_checker.md
# gpio_sequence_checker

Synthesizable, parametrised on-chip checker for user-project GPIO patterns, placed in the user project area beside the logic that drives `mprj_io`. It generalises our simulation-only "wait for `mprj_io[7:0] == 8'h12`, else time out" check into hardware:
- configurable width
- a programmable sequence of up to DEPTH masked patterns
- per-step timeout
- glitch filtering
- a pass/fail result with the failing step index

It lets silicon bring-up and firmware self-check the same IO sequences the benches check.

## Interface
Parameters:
- `WIDTH`, 8, monitored IO bits
- `DEPTH`, 4, max sequence steps
- `TIMEOUT_W`, 16, timeout counter width
- `STABLE_CYCLES`, 2, consecutive synchronized matches required per step (≥1)

Ports:
- `wb_clk_i`  in  1  sole clock
- `wb_rst_i`  in  1  reset; synchronous, active-high
- `io_in`  in  WIDTH  asynchronous IO sample (`mprj_io` slice)
- `cfg_we`  in  1  write step entry
- `cfg_addr`  in  `$clog2(DEPTH)`  step index to write
- `cfg_pattern`  in  WIDTH  expected value
- `cfg_mask`  in  WIDTH  1 = bit compared
- `cfg_len`  in  `$clog2(DEPTH+1)`  active steps (0..DEPTH); sampled at start
- `cfg_timeout`  in  TIMEOUT_W  per-step cycle limit; 0 = no timeout; sampled at start
- `start`  in  1  pulse: begin run
- `abort`  in  1  pulse: cancel run
- `busy`  out  1  run in progress
- `done`  out  1  result valid
- `pass`  out  1  sequence completed
- `step`  out  `$clog2(DEPTH)`  current step; holds failing step on fail

## Operation
- `io_in` passes through a 2-flop synchronizer. `match = ((sync ^ pattern[step]) & mask[step]) == 0`.
- States:
  - IDLE → RUN on `start`, or → PASS if `cfg_len`==0.
  - RUN: on each edge with `match`, `stable_cnt` increments. A mismatch clears `stable_cnt`; the step timer is not cleared.
  - When `stable_cnt` reaches STABLE_CYCLES:
    - If `step`==`len`-1 → PASS.
    - Otherwise `step`++, and `stable_cnt` and timer clear.
  - Timer increments every RUN cycle. Timer == `timeout`-1 without an advance on that edge → FAIL. If advance and timeout coincide, the advance wins.
  - PASS/FAIL hold until `start` (new run, restarting at step 0) or reset.
- `abort` in any state → IDLE, with `done`=0, `pass`=0, `step`=0. `abort` and `start` on the same edge: abort wins.
- `start` while in RUN is ignored.
- `cfg_we` while `busy` is ignored. In IDLE/PASS/FAIL it writes `pattern[cfg_addr]` and `mask[cfg_addr]`.
- `cfg_addr` ≥ DEPTH writes are dropped. `cfg_len` > DEPTH is clamped to DEPTH.
- Mask of all zeros: the step matches unconditionally and advances after STABLE_CYCLES cycles.

## Timing
- Reset values:
  - outputs: `busy`=0, `done`=0, `pass`=0, `step`=0
  - pattern/mask storage: all zeros
  - synchronizer flops: 0
- `busy`=1 exactly in RUN. `done`=1 in PASS/FAIL. `pass`=1 only in PASS. All outputs are registered.
- `start` at edge N: `busy` high after N; step 0 is evaluated from edge N+1.
- Latency, `io_in` change (stable before edge K) to advance: edge K+1+STABLE_CYCLES. `done`/`pass` become visible after that edge. With defaults, the last step passes 4 edges after the input settles.
- Timeout T: FAIL registered on the T-th RUN edge of the step.
- Reset mid-run returns all state to reset values on that edge.

## Structure
- Package `gpio_chk_pkg`: state enum (IDLE, RUN, PASS, FAIL), width helper constants.
- Sub-module `gpio_sync`: parametrised WIDTH, 2-flop synchronizer, synchronous reset.
- Storage is flop arrays (DEPTH×2×WIDTH); no SRAM.

## Test plan
Defaults unless noted; `cfg_timeout`=100.
- Single step, pattern 0x12, mask 0xFF, `cfg_len`=1. Drive 0x00, then 0x12 at cycle 10 → `pass`=1, `done`=1 at cycle 14; `busy` falls the same edge.
- Two steps {0x12, 0x34}. Drive 0x34 then 0x12 → step 0 passes, then FAIL at `step`=1 when the step-1 timer expires. Correct order → pass.
- Glitch: 0x12 for 1 cycle among 0x00, `cfg_timeout`=50 → no advance; FAIL with `step`=0 on the 50th RUN edge.
- Mask: pattern 0xA0, mask 0xF0, drive 0xA7 → pass. Drive 0xB0 → FAIL.
- Edge cases, each expecting the stated response:
  - `cfg_len`=0 → PASS one edge after `start`.
  - `start`+`abort` on the same edge → IDLE.
  - `cfg_we` during RUN → pattern unchanged (verify with a second run).
- `wb_rst_i` asserted mid-RUN at step 2 of 4 → all outputs 0 the next cycle. A fresh run with the same patterns passes.
